// File: rtl/soc_clk_rst_seq_pkg.sv
// Shared types and constants for the per-domain clock/reset sequencer.
package soc_clk_rst_seq_pkg;

  localparam int REF_DIV_BW = 6;
  localparam int FB_DIV_BW  = 8;

  localparam logic [REF_DIV_BW-1:0] REF_DIV_DEFAULT = 6'd1;
  localparam logic [FB_DIV_BW-1:0]  FB_DIV_DEFAULT  = 8'd40;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    ASSERT_RST,
    GATE,
    PLL_PROG,
    PLL_LOCK,
    UNGATE,
    RELEASE
  } clk_rst_seq_state_e;

  typedef struct packed {
    logic                  clk_en;
    logic                  rst_req;
    logic [REF_DIV_BW-1:0] ref_div;
    logic [FB_DIV_BW-1:0]  fb_div;
  } clk_rst_seq_cfg_t;

  function automatic logic div_differs(input clk_rst_seq_cfg_t cfg,
                                       input logic [REF_DIV_BW-1:0] ref_div,
                                       input logic [FB_DIV_BW-1:0] fb_div);
    return (cfg.ref_div != ref_div) || (cfg.fb_div != fb_div);
  endfunction

endpackage

// File: rtl/soc_clk_rst_seq_if.sv
// Request/PLL/domain signal bundle between control registers, sequencer and clock/reset cells.
interface soc_clk_rst_seq_if;
  import soc_clk_rst_seq_pkg::*;

  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic                  clk_en_i;
  logic                  rst_req_i;
  logic [REF_DIV_BW-1:0] ref_div_i;
  logic [FB_DIV_BW-1:0]  fb_div_i;
  logic [REF_DIV_BW-1:0] pll_ref_div_o;
  logic [FB_DIV_BW-1:0]  pll_fb_div_o;
  logic                  pll_locked_i;
  logic                  clk_gate_en_o;
  logic                  dom_rst_no;
  logic                  busy_o;
  logic                  lock_err_o;

  modport slave (
    input  cfg_valid_i, clk_en_i, rst_req_i, ref_div_i, fb_div_i, pll_locked_i,
    output cfg_ready_o, pll_ref_div_o, pll_fb_div_o, clk_gate_en_o, dom_rst_no,
           busy_o, lock_err_o
  );

  modport master (
    output cfg_valid_i, clk_en_i, rst_req_i, ref_div_i, fb_div_i, pll_locked_i,
    input  cfg_ready_o, pll_ref_div_o, pll_fb_div_o, clk_gate_en_o, dom_rst_no,
           busy_o, lock_err_o
  );

endinterface

// File: rtl/soc_clk_rst_seq_timer.sv
// Loadable down-counter; done is high for the single cycle the count reads 1.
module soc_clk_rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/soc_clk_rst_seq.sv
// Per-domain clock/reset sequencer: reset, gate, reprogram PLL, lock, ungate, release.
// Optional lock timeout enabled by defining SOC_CLK_RST_SEQ_LOCK_TIMEOUT_EN.
//
// state      | meaning
// BOOT       | first cycle after reset, optional auto sequence
// IDLE       | outputs held, ready for a request
// ASSERT_RST | domain reset asserted, settle
// GATE       | clock gated, settle
// PLL_PROG   | new dividers driven, settle
// PLL_LOCK   | waiting for PLL lock (optionally bounded)
// UNGATE     | clock gate follows requested enable, settle
// RELEASE    | domain reset released if enabled and not held
module soc_clk_rst_seq
  import soc_clk_rst_seq_pkg::*;
#(
  parameter int unsigned           SETTLE_CYC   = 4,
  parameter int unsigned           LOCK_TIMEOUT = 256,
  parameter logic [REF_DIV_BW-1:0] REF_DIV_RST  = REF_DIV_DEFAULT,
  parameter logic [FB_DIV_BW-1:0]  FB_DIV_RST   = FB_DIV_DEFAULT,
  parameter int unsigned           BOOT_ON      = 1
) (
  input logic              clk_i,
  input logic              arst_ni,
  soc_clk_rst_seq_if.slave seq
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  clk_rst_seq_state_e    state_q, state_d;
  clk_rst_seq_cfg_t      cap_q;
  logic                  cap_load;
  logic                  timeout;
  logic                  gate_q;
  logic                  rst_n_q;
  logic [REF_DIV_BW-1:0] ref_div_q;
  logic [FB_DIV_BW-1:0]  fb_div_q;
  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  tmr_done;

  always_comb begin
    state_d  = state_q;
    cap_load = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      BOOT:       state_d = (BOOT_ON != 0) ? ASSERT_RST : IDLE;
      IDLE: begin
        if (seq.cfg_valid_i) begin
          cap_load = 1'b1;
          state_d  = ASSERT_RST;
        end
      end
      ASSERT_RST: if (tmr_done) state_d = GATE;
      GATE: begin
        if (tmr_done) state_d = div_differs(cap_q, ref_div_q, fb_div_q) ? PLL_PROG : UNGATE;
      end
      PLL_PROG:   if (tmr_done) state_d = PLL_LOCK;
      PLL_LOCK: begin
        if (seq.pll_locked_i) state_d = UNGATE;
`ifdef SOC_CLK_RST_SEQ_LOCK_TIMEOUT_EN
        else if (tmr_done) begin
          state_d = IDLE;
          timeout = 1'b1;
        end
`endif
      end
      UNGATE:     if (tmr_done) state_d = RELEASE;
      RELEASE:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Every state entry restarts the timer; only timed states look at done.
  assign tmr_load = (state_d != state_q);
  assign tmr_val  = (state_d == PLL_LOCK) ? CNT_W'(LOCK_TIMEOUT) : CNT_W'(SETTLE_CYC);

  soc_clk_rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q       <= BOOT;
      cap_q.clk_en  <= (BOOT_ON != 0);
      cap_q.rst_req <= (BOOT_ON == 0);
      cap_q.ref_div <= REF_DIV_RST;
      cap_q.fb_div  <= FB_DIV_RST;
      gate_q        <= 1'b0;
      rst_n_q       <= 1'b0;
      ref_div_q     <= REF_DIV_RST;
      fb_div_q      <= FB_DIV_RST;
    end else begin
      state_q <= state_d;
      if (cap_load) begin
        cap_q.clk_en  <= seq.clk_en_i;
        cap_q.rst_req <= seq.rst_req_i;
        cap_q.ref_div <= seq.ref_div_i;
        cap_q.fb_div  <= seq.fb_div_i;
      end
      if (state_d != state_q) begin
        case (state_d)
          ASSERT_RST: rst_n_q <= 1'b0;
          GATE:       gate_q  <= 1'b0;
          PLL_PROG: begin
            ref_div_q <= cap_q.ref_div;
            fb_div_q  <= cap_q.fb_div;
          end
          UNGATE:     gate_q  <= cap_q.clk_en;
          // Releasing only with the clock enabled keeps reset held whenever the gate is off.
          RELEASE:    rst_n_q <= cap_q.clk_en & ~cap_q.rst_req;
          default:    ;
        endcase
      end
      if (timeout) begin
        gate_q  <= 1'b0;
        rst_n_q <= 1'b0;
      end
    end
  end

`ifdef SOC_CLK_RST_SEQ_LOCK_TIMEOUT_EN
  logic lock_err_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_err_q <= 1'b0;
    end else if (timeout) begin
      lock_err_q <= 1'b1;
    end
  end

  assign seq.lock_err_o = lock_err_q;
`else
  assign seq.lock_err_o = 1'b0;
`endif

  assign seq.cfg_ready_o   = (state_q == IDLE);
  assign seq.busy_o        = (state_q != IDLE) && (state_q != BOOT);
  assign seq.clk_gate_en_o = gate_q;
  assign seq.dom_rst_no    = rst_n_q;
  assign seq.pll_ref_div_o = ref_div_q;
  assign seq.pll_fb_div_o  = fb_div_q;

endmodule
